rgb_fade_sequencer: RTL and testbench

- Upstream colour source for the three-LED PL9823 serial driver.
- Holds a target colour per LED, written through a valid/ready port.
- Ramps the nine live colour channels toward their targets by a fixed step once per fade tick.
- Live channels drive the driver's D1..D3 ROT/GRUEN/BLAU inputs directly.

---
 rtl/rgb_fade_sequencer.sv | 146 ++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_sequencer.sv
// Colour source for a three-LED PL9823 chain: per-LED targets written over valid/ready,
// nine live channels stepped toward them once per fade tick. Gamma stage: RGB_FADE_GAMMA_EN.
module rgb_fade_sequencer #(
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [1:0] WR_LED,
  input  logic [7:0] WR_ROT,
  input  logic [7:0] WR_GRUEN,
  input  logic [7:0] WR_BLAU,
  output logic [7:0] D1_ROT,
  output logic [7:0] D1_GRUEN,
  output logic [7:0] D1_BLAU,
  output logic [7:0] D2_ROT,
  output logic [7:0] D2_GRUEN,
  output logic [7:0] D2_BLAU,
  output logic [7:0] D3_ROT,
  output logic [7:0] D3_GRUEN,
  output logic [7:0] D3_BLAU,
  output logic       BUSY
);

  localparam logic       ST_IDLE   = 1'b0;
  localparam logic       ST_UPDATE = 1'b1;
  localparam int         CW        = $clog2(TICK_DIV);
  localparam logic [8:0] STEP9     = 9'(STEP);
  localparam logic [7:0] STEP8     = 8'(STEP);

  // Move one channel toward its target by at most STEP, never past it.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] diff;
    if (cur < tgt) begin
      diff        = {1'b0, tgt} - {1'b0, cur};
      step_toward = (diff > STEP9) ? cur + STEP8 : tgt;
    end else if (cur > tgt) begin
      diff        = {1'b0, cur} - {1'b0, tgt};
      step_toward = (diff > STEP9) ? cur - STEP8 : tgt;
    end else begin
      diff        = 9'd0;
      step_toward = cur;
    end
  endfunction

  logic          state_r;
  logic [CW-1:0] cnt_r;
  logic [7:0]    cur_r     [9];
  logic [7:0]    tgt_r     [9];
  logic [7:0]    cur_nxt_s [9];
  logic [7:0]    tgt_nxt_s [9];
  logic [7:0]    wr_col_s  [3];
  logic [7:0]    d_s       [9];
  logic          busy_r;
  logic          busy_nxt_s;
  logic          accept_s;
  logic          tick_s;

  assign tick_s   = (cnt_r == CW'(TICK_DIV - 1));
  assign WR_READY = (state_r == ST_IDLE) && !RST;
  assign BUSY     = busy_r;

  // Next target and live values; BUSY is derived from the values about to be stored.
  always_comb begin
    accept_s    = WR_VALID && WR_READY;
    wr_col_s[0] = WR_ROT;
    wr_col_s[1] = WR_GRUEN;
    wr_col_s[2] = WR_BLAU;
    busy_nxt_s  = 1'b0;
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 3; c++) begin
        if (accept_s && ((WR_LED == 2'd3) || (WR_LED == 2'(l)))) begin
          tgt_nxt_s[l*3+c] = wr_col_s[c];
        end else begin
          tgt_nxt_s[l*3+c] = tgt_r[l*3+c];
        end
        if (state_r == ST_UPDATE) begin
          cur_nxt_s[l*3+c] = step_toward(cur_r[l*3+c], tgt_r[l*3+c]);
        end else begin
          cur_nxt_s[l*3+c] = cur_r[l*3+c];
        end
        busy_nxt_s = busy_nxt_s | (cur_nxt_s[l*3+c] != tgt_nxt_s[l*3+c]);
      end
    end
  end

  // Tick counter, two-state sequencer, channel registers and BUSY.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        cur_r[i] <= 8'd0;
        tgt_r[i] <= 8'd0;
      end
    end else begin
      cnt_r <= tick_s ? {CW{1'b0}} : cnt_r + CW'(1);
      case (state_r)
        ST_IDLE:   state_r <= tick_s ? ST_UPDATE : ST_IDLE;
        ST_UPDATE: state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
      busy_r <= busy_nxt_s;
      for (int i = 0; i < 9; i++) begin
        cur_r[i] <= cur_nxt_s[i];
        tgt_r[i] <= tgt_nxt_s[i];
      end
    end
  end

`ifdef RGB_FADE_GAMMA_EN
  // Rounded-up square law: 0->0, 1->1, 128->64, 255->255.
  function automatic logic [7:0] gamma_fn(input logic [7:0] v);
    gamma_fn = 8'((16'(v) * 16'(v) + 16'd255) >> 8);
  endfunction

  logic [7:0] gam_r [9];

  // Registered gamma stage, one cycle behind the live channels.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 9; i++) gam_r[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 9; i++) gam_r[i] <= gamma_fn(cur_r[i]);
    end
  end

  assign d_s = gam_r;
`else
  assign d_s = cur_r;
`endif

  assign D1_ROT   = d_s[0];
  assign D1_GRUEN = d_s[1];
  assign D1_BLAU  = d_s[2];
  assign D2_ROT   = d_s[3];
  assign D2_GRUEN = d_s[4];
  assign D2_BLAU  = d_s[5];
  assign D3_ROT   = d_s[6];
  assign D3_GRUEN = d_s[7];
  assign D3_BLAU  = d_s[8];

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer: a cycle-indexed colour model queues the expected
// outputs of every cycle and a negedge monitor compares them against the DUT.
module tb_rgb_fade_sequencer;

  localparam int TICK_DIV = 4;
  localparam int STEP     = 10;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WR_VALID;
  logic       WR_READY;
  logic [1:0] WR_LED;
  logic [7:0] WR_ROT, WR_GRUEN, WR_BLAU;
  logic [7:0] D1_ROT, D1_GRUEN, D1_BLAU;
  logic [7:0] D2_ROT, D2_GRUEN, D2_BLAU;
  logic [7:0] D3_ROT, D3_GRUEN, D3_BLAU;
  logic       BUSY;

  rgb_fade_sequencer #(.TICK_DIV(TICK_DIV), .STEP(STEP)) dut (
    .CLK(CLK), .RST(RST),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_LED(WR_LED),
    .WR_ROT(WR_ROT), .WR_GRUEN(WR_GRUEN), .WR_BLAU(WR_BLAU),
    .D1_ROT(D1_ROT), .D1_GRUEN(D1_GRUEN), .D1_BLAU(D1_BLAU),
    .D2_ROT(D2_ROT), .D2_GRUEN(D2_GRUEN), .D2_BLAU(D2_BLAU),
    .D3_ROT(D3_ROT), .D3_GRUEN(D3_GRUEN), .D3_BLAU(D3_BLAU),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [71:0] d;
    logic        busy;
    logic        ready;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests    = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: k counts cycles since reset release; cycles k=TICK_DIV,2*TICK_DIV,... update.
  int cur[9], tgt[9], gam[9];
  int k      = 0;
  bit busy_m = 1'b0;

  function automatic int gamma_of(int v);
    return (v * v + 255) / 256;
  endfunction

  function automatic bit is_upd();
    return (k > 0) && (k % TICK_DIV == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      cur[i] = 0; tgt[i] = 0; gam[i] = 0;
    end
    k = 0;
    busy_m = 1'b0;
  endtask

  task automatic model_edge();
    int d;
    bit upd;
    if (RST) begin
      model_reset();
    end else begin
      upd = is_upd();
      if (WR_VALID && !upd) begin
        for (int l = 0; l < 3; l++) begin
          if (WR_LED == 2'd3 || int'(WR_LED) == l) begin
            tgt[l*3] = WR_ROT; tgt[l*3+1] = WR_GRUEN; tgt[l*3+2] = WR_BLAU;
          end
        end
      end
      for (int i = 0; i < 9; i++) gam[i] = gamma_of(cur[i]);
      if (upd) begin
        for (int i = 0; i < 9; i++) begin
          d = tgt[i] - cur[i];
          if (d > 0) cur[i] += (d < STEP) ? d : STEP;
          else if (d < 0) cur[i] -= (-d < STEP) ? -d : STEP;
        end
      end
      busy_m = 1'b0;
      for (int i = 0; i < 9; i++) if (cur[i] != tgt[i]) busy_m = 1'b1;
      k++;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
`ifdef RGB_FADE_GAMMA_EN
      e.d[71-8*i -: 8] = 8'(gam[i]);
`else
      e.d[71-8*i -: 8] = 8'(cur[i]);
`endif
    end
    e.busy  = busy_m;
    e.ready = !RST && !is_upd();
    e.cyc   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    push_expect();
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
    if (!WR_VALID) begin
      WR_ROT = 8'($urandom); WR_GRUEN = 8'($urandom); WR_BLAU = 8'($urandom);
      WR_LED = 2'($urandom);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && busy_m; i++) cycle();
    run_cycles(2);
  endtask

  // Request is held until the cycle it is accepted; an update cycle delays it by one.
  task automatic do_write(input logic [1:0] led, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
    WR_VALID = 1'b1; WR_LED = led; WR_ROT = r; WR_GRUEN = g; WR_BLAU = b;
    if (is_upd()) cycle();
    cycle();
    WR_VALID = 1'b0;
  endtask

  exp_t        mon_e;
  logic [71:0] got_d;

  // Monitor: one queued expectation per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      got_d = {D1_ROT, D1_GRUEN, D1_BLAU, D2_ROT, D2_GRUEN, D2_BLAU, D3_ROT, D3_GRUEN, D3_BLAU};
      tests += 3;
      if (got_d !== mon_e.d) begin
        failures++;
        $display("FAIL d_out cycle %0d: got %h expected %h", mon_e.cyc, got_d, mon_e.d);
      end
      if (BUSY !== mon_e.busy) begin
        failures++;
        $display("FAIL busy cycle %0d: got %b expected %b", mon_e.cyc, BUSY, mon_e.busy);
      end
      if (WR_READY !== mon_e.ready) begin
        failures++;
        $display("FAIL wr_ready cycle %0d: got %b expected %b", mon_e.cyc, WR_READY, mon_e.ready);
      end
    end
  end

  initial begin
    RST = 1'b1; WR_VALID = 1'b0; WR_LED = 2'd0;
    WR_ROT = 8'd0; WR_GRUEN = 8'd0; WR_BLAU = 8'd0;
    model_reset();
    @(posedge CLK);
    #1;
    cycle();
    RST = 1'b0;
    run_cycles(6);

    do_write(2'd0, 8'd3, 8'd0, 8'd255);
    run_until_idle(400);

    do_write(2'd0, 8'd250, 8'd0, 8'd250);
    run_until_idle(400);
    do_write(2'd0, 8'd255, 8'd0, 8'd255);
    run_until_idle(40);
    do_write(2'd0, 8'd3, 8'd0, 8'd3);
    run_until_idle(400);

    while (!is_upd()) cycle();
    do_write(2'd1, 8'd40, 8'd50, 8'd60);
    run_until_idle(200);

    do_write(2'd3, 8'd10, 8'd20, 8'd30);
    run_cycles(9);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    run_cycles(12);

    do_write(2'd0, 8'd128, 8'd255, 8'd1);
    run_until_idle(400);

    for (int n = 0; n < 30; n++) begin
      run_cycles($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) begin
        RST = 1'b1;
        cycle();
        RST = 1'b0;
      end
      do_write(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    run_until_idle(2000);

    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
